// File: rtl/keypad_entry.sv
// ----------------------------------------------------------------------------
// keypad_entry
//
// Scans a 4x4 active-low matrix keypad, debounces press and release, collects
// up to MAX_DIGITS decimal digits as packed BCD (ready to drive the 8-digit
// seven-segment display), and on Enter converts the BCD to binary with a
// sequential reverse double-dabble (one bit per clk_1000 cycle).
//
// Key map (key_code = row*4 + col):
//   0-9 : digit          A : clear entry      B : backspace
//   C-E : no entry action (still reported on key_valid)
//   F   : enter (start BCD-to-binary conversion)
//
// Ports:
//   clk_1000      in   1   system tick clock, rising edge
//   rst           in   1   synchronous reset, active-high
//   col_in        in   4   keypad columns, active-low, pulled up, synchronised
//   row_out       out  4   keypad row drive, active-low one-hot
//   key_valid     out  1   one-cycle pulse per accepted key
//   key_code      out  4   code of the last accepted key (held)
//   entry_bcd     out 32   digits entered so far, nibble 0 is the newest
//   entry_digits  out  4   number of digits entered (0..MAX_DIGITS)
//   busy          out  1   conversion in progress
//   entry_value   out 32   binary result of the last conversion (held)
//   entry_done    out  1   one-cycle pulse when entry_value updates
//
// Build option:
//   KEYPAD_AUTOREPEAT_EN  when defined, a held digit or backspace key
//                         auto-repeats after REPEAT_DELAY cycles and then
//                         every REPEAT_RATE cycles. When undefined, exactly
//                         one key_valid is produced per press.
//
// Scanner states:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_SCAN      | drive row cur_row for SCAN_HOLD cycles, sample on the last
//   S_PRESS_DB  | row held, counting consecutive low samples on cur_col
//   S_HELD      | key accepted, waiting for the column to go high
//   S_REL_DB    | counting consecutive high samples before rescanning
// ----------------------------------------------------------------------------
module keypad_entry #(
    parameter int SCAN_HOLD    = 4,
    parameter int DEBOUNCE     = 20,
    parameter int MAX_DIGITS   = 8,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic        clk_1000,
    input  logic        rst,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] entry_bcd,
    output logic [3:0]  entry_digits,
    output logic        busy,
    output logic [31:0] entry_value,
    output logic        entry_done
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    if (SCAN_HOLD < 2) begin : g_bad_scan_hold
        $error("keypad_entry: SCAN_HOLD must be at least 2");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("keypad_entry: DEBOUNCE must be at least 1");
    end
    if ((MAX_DIGITS < 1) || (MAX_DIGITS > 8)) begin : g_bad_max_digits
        $error("keypad_entry: MAX_DIGITS must be in 1..8");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
        $error("keypad_entry: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
    localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [3:0]        MAX_DIG   = 4'(MAX_DIGITS);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    localparam logic [5:0] CONV_ITERS = 6'd32;

    typedef enum logic [1:0] {
        S_SCAN,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } scan_state_t;

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        row_drive = ~(4'b0001 << r);
    endfunction

    // ------------------------------------------------------------------
    // Scanner
    // ------------------------------------------------------------------
    scan_state_t       state;
    logic [1:0]        cur_row;
    logic [1:0]        cur_col;
    logic [1:0]        next_row;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DB_W-1:0]   db_cnt;
    logic              any_low;
    logic [1:0]        low_col;
    logic              col_sel;

    assign next_row = cur_row + 2'd1;
    assign any_low  = ~&col_in;
    assign col_sel  = col_in[cur_col];

    // Lowest-index low column wins when several keys share the driven row.
    always_comb begin
        low_col = 2'd3;
        if (!col_in[0]) begin
            low_col = 2'd0;
        end else if (!col_in[1]) begin
            low_col = 2'd1;
        end else if (!col_in[2]) begin
            low_col = 2'd2;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_ok;

    // Only digits and backspace repeat; repeating clear or enter is useless
    // at best and would restart conversions at worst.
    assign rpt_ok = ({cur_row, cur_col} <= 4'd9) || ({cur_row, cur_col} == KEY_BACK);
`endif

    always_ff @(posedge clk_1000) begin
        if (rst) begin
            state     <= S_SCAN;
            cur_row   <= 2'd0;
            cur_col   <= 2'd0;
            hold_cnt  <= HOLD_LAST;
            db_cnt    <= DB_LAST;
            row_out   <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                S_SCAN: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else if (any_low) begin
                        cur_col <= low_col;
                        db_cnt  <= DB_LAST;
                        state   <= S_PRESS_DB;
                    end else begin
                        cur_row  <= next_row;
                        row_out  <= row_drive(next_row);
                        hold_cnt <= HOLD_LAST;
                    end
                end

                S_PRESS_DB: begin
                    if (col_sel) begin
                        // Bounce: abandon this key and carry on scanning.
                        cur_row  <= next_row;
                        row_out  <= row_drive(next_row);
                        hold_cnt <= HOLD_LAST;
                        state    <= S_SCAN;
                    end else if (db_cnt == '0) begin
                        key_valid <= 1'b1;
                        key_code  <= {cur_row, cur_col};
                        state     <= S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_cnt   <= RPT_DELAY_LAST;
`endif
                    end else begin
                        db_cnt <= db_cnt - DB_W'(1);
                    end
                end

                S_HELD: begin
                    if (col_sel) begin
                        db_cnt <= DB_LAST;
                        state  <= S_REL_DB;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rpt_ok) begin
                        if (rpt_cnt == '0) begin
                            key_valid <= 1'b1;
                            rpt_cnt   <= RPT_RATE_LAST;
                        end else begin
                            rpt_cnt <= rpt_cnt - RPT_W'(1);
                        end
                    end
`endif
                end

                S_REL_DB: begin
                    if (!col_sel) begin
                        state <= S_HELD;
                    end else if (db_cnt == '0) begin
                        cur_row  <= next_row;
                        row_out  <= row_drive(next_row);
                        hold_cnt <= HOLD_LAST;
                        state    <= S_SCAN;
                    end else begin
                        db_cnt <= db_cnt - DB_W'(1);
                    end
                end

                default: begin
                    state <= S_SCAN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry buffer and BCD-to-binary conversion
    // ------------------------------------------------------------------
    logic [31:0] conv_bcd;
    logic [31:0] conv_bin;
    logic [5:0]  iter_cnt;
    logic [31:0] step_bcd;
    logic [31:0] step_bin;

    // One reverse double-dabble step: shift the {bcd, bin} pair right, then
    // any BCD nibble that now reads 8 or more had a 1 shifted in from the
    // digit above (worth 10, shows as 8), so take 3 off to keep it decimal.
    always_comb begin
        {step_bcd, step_bin} = {1'b0, conv_bcd, conv_bin[31:1]};
        for (int i = 0; i < 8; i++) begin
            if (step_bcd[4*i +: 4] >= 4'd8) begin
                step_bcd[4*i +: 4] = step_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk_1000) begin
        if (rst) begin
            entry_bcd    <= 32'd0;
            entry_digits <= 4'd0;
            busy         <= 1'b0;
            entry_value  <= 32'd0;
            entry_done   <= 1'b0;
            conv_bcd     <= 32'd0;
            conv_bin     <= 32'd0;
            iter_cnt     <= 6'd0;
        end else begin
            entry_done <= 1'b0;
            if (busy) begin
                // Keys arriving during a conversion are dropped here.
                if (iter_cnt != 6'd0) begin
                    conv_bcd <= step_bcd;
                    conv_bin <= step_bin;
                    iter_cnt <= iter_cnt - 6'd1;
                end else begin
                    entry_value  <= conv_bin;
                    entry_done   <= 1'b1;
                    busy         <= 1'b0;
                    entry_bcd    <= 32'd0;
                    entry_digits <= 4'd0;
                end
            end else if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (entry_digits < MAX_DIG) begin
                        entry_bcd    <= {entry_bcd[27:0], key_code};
                        entry_digits <= entry_digits + 4'd1;
                    end
                end else begin
                    case (key_code)
                        KEY_CLEAR: begin
                            entry_bcd    <= 32'd0;
                            entry_digits <= 4'd0;
                        end
                        KEY_BACK: begin
                            if (entry_digits != 4'd0) begin
                                entry_bcd    <= {4'd0, entry_bcd[31:4]};
                                entry_digits <= entry_digits - 4'd1;
                            end
                        end
                        KEY_ENTER: begin
                            busy     <= 1'b1;
                            conv_bcd <= entry_bcd;
                            conv_bin <= 32'd0;
                            iter_cnt <= CONV_ITERS;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the 8-digit scanned seven-segment display.
- Scans a 4x4 active-low matrix keypad and debounces press and release.
- Accumulates up to 8 decimal digits as BCD, which can drive the display directly.
- On Enter, converts the BCD to binary with a sequential reverse double-dabble, producing the game-setting value.

Parameters:
- SCAN_HOLD, 4: clk_1000 cycles each row is driven before its columns are sampled (>=2).
- DEBOUNCE, 20: consecutive stable cycles required to accept a press or a release.
- MAX_DIGITS, 8: maximum digits accepted (1..8).
- REPEAT_DELAY, 500: cycles held before the first auto-repeat (optional feature only).
- REPEAT_RATE, 100: cycles between auto-repeats (optional feature only).

Ports:
- clk_1000, input, 1: system tick clock; all logic on its rising edge.
- rst, input, 1: synchronous reset, active-high.
- col_in, input, 4: keypad columns, active-low, externally pulled up; already synchronised.
- row_out, output, 4: keypad row drive, active-low one-hot.
- key_valid, output, 1: one-cycle pulse per accepted key.
- key_code, output, 4: code of the accepted key, row*4+col; held until the next key.
- entry_bcd, output, 32: digits entered so far; nibble 0 is the newest digit.
- entry_digits, output, 4: count of digits entered (0..MAX_DIGITS).
- busy, output, 1: high while a BCD-to-binary conversion runs.
- entry_value, output, 32: binary result of the last conversion; held until the next one.
- entry_done, output, 1: one-cycle pulse when entry_value updates.

Behaviour:
- Reset (synchronous): all outputs 0 except row_out=4'b1110. Scanner enters SCAN at row 0 with counters cleared. Reset during any state, including mid-conversion, aborts it.
- Scanner states:
  - SCAN: drive row r for SCAN_HOLD cycles, sampling col_in on the last cycle. If any column is low, latch r and the lowest-index low column c, then go to PRESS_DB. Otherwise advance r (3 wraps to 0).
  - PRESS_DB: row r stays driven. Count cycles with col_in[c]=0. Any high sample returns to SCAN with the next row and no key. On the DEBOUNCE-th low cycle, pulse key_valid, set key_code={r,c}, and go to HELD.
  - HELD: remain while col_in[c]=0; on a high sample, go to REL_DB.
  - REL_DB: count cycles with col_in[c]=1; any low sample returns to HELD. On the DEBOUNCE-th high cycle, go to SCAN with the next row.
  - Other keys pressed while in PRESS_DB, HELD or REL_DB are ignored. There is no rollover.
- Key actions (taken in the cycle after key_valid):
  - Codes 0-9 are digits. If busy=0 and entry_digits<MAX_DIGITS: entry_bcd<=(entry_bcd<<4)|code and entry_digits+1. Otherwise the digit is dropped.
  - 4'hA is Clear: entry_bcd=0, entry_digits=0.
  - 4'hB is Backspace: entry_bcd>>=4, entry_digits-1. No effect at 0 digits.
  - 4'hF is Enter: start conversion. Enter with 0 digits converts to 0.
  - 4'hC, 4'hD, 4'hE are ignored for entry but still pulse key_valid.
  - While busy=1, Clear, Backspace and Enter are all ignored.
- Conversion:
  - On Enter, busy rises and working registers load {bcd, bin}={entry_bcd, 32'd0}.
  - 32 iterations, one per cycle. Each iteration shifts the 64-bit pair right by one, then subtracts 3 from every BCD nibble that is >=8.
  - After the 32nd iteration: entry_value<=bin, entry_done pulses, busy falls, entry_bcd and entry_digits clear. All of these happen in the same cycle.
  - Latency: entry_done occurs 34 cycles after the Enter key_valid cycle.
- Width: the maximum 99,999,999 fits 27 bits. Upper bits of entry_value are 0.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, after REPEAT_DELAY cycles of continuous hold, key_valid pulses with the same key_code. It then re-pulses every REPEAT_RATE cycles while the key is held. Repeats apply to digits and Backspace only, not to Clear or Enter.
- Undefined: exactly one key_valid per press; the REPEAT parameters are unused.

Test Plan:
- Reset, no keys (SCAN_HOLD=4, DEBOUNCE=20): row_out cycles 1110,1101,1011,0111, each for 4 cycles; key_valid stays 0.
- Press r1c2 steadily: one key_valid with key_code=6; entry_bcd=32'h6, entry_digits=1. No second pulse on release.
- Bounce: col low 7 cycles, high 1, then low 30 cycles: exactly one key_valid, counted from the restart.
- Enter 1,2,3,4,5,6,7,8,9 then Enter: the 9th digit is dropped (entry_bcd=32'h12345678). entry_done 34 cycles after Enter with entry_value=12345678 (0x00BC614E); then entry_bcd=0.
- Keys 4,2,B,7,F: entry_bcd=32'h47 before Enter; entry_value=47. A Clear during busy changes nothing.
- Assert rst mid-conversion at iteration 10: all outputs 0, row_out=1110, no entry_done.
